// File: rtl/seg_pkg.sv
// Shared definitions for the seven-segment scan multiplexer: scan states,
// segment bit positions and the hex glyph table (bits 6:0 = g..a).
package seg_pkg;

  typedef enum logic {
    BLANK = 1'b0,
    SHOW  = 1'b1
  } scan_state_t;

  localparam int SEG_A  = 0;
  localparam int SEG_B  = 1;
  localparam int SEG_C  = 2;
  localparam int SEG_D  = 3;
  localparam int SEG_E  = 4;
  localparam int SEG_F  = 5;
  localparam int SEG_G  = 6;
  localparam int SEG_DP = 7;

  localparam logic [6:0] SEG_TABLE [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

endpackage

// File: rtl/seg_decoder.sv
// Combinational hex nibble + decimal point to active-high segment pattern.
module seg_decoder
  import seg_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       dp,
  output logic [7:0] seg
);

  logic [6:0] glyph;

  always_comb begin
    glyph       = SEG_TABLE[nibble];
    seg         = '0;
    seg[SEG_A]  = glyph[0];
    seg[SEG_B]  = glyph[1];
    seg[SEG_C]  = glyph[2];
    seg[SEG_D]  = glyph[3];
    seg[SEG_E]  = glyph[4];
    seg[SEG_F]  = glyph[5];
    seg[SEG_G]  = glyph[6];
    seg[SEG_DP] = dp;
  end

endmodule

// File: rtl/seg_scan_mux.sv
// Multiplexed seven-segment scanner with double-buffered display word and
// blank gaps between digits. Optional macro: LEADING_ZERO_BLANK_EN.
module seg_scan_mux
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 5000,
  parameter int BLANK_CYCLES = 50
) (
  input  logic                    CLOCK,
  input  logic                    RESET_N,
  input  logic                    load_valid,
  output logic                    load_ready,
  input  logic [4*NUM_DIGITS-1:0] load_digits,
  input  logic [NUM_DIGITS-1:0]   load_dp,
  output logic [7:0]              seg_out,
  output logic [NUM_DIGITS-1:0]   dig_sel,
  output logic                    frame_tick
);

  localparam int MAX_CNT = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
  localparam int CW      = $clog2(MAX_CNT + 1);
  localparam int IW      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [CW-1:0] SHOW_LAST  = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

  if (REFRESH_DIV < 1 || BLANK_CYCLES < 1) begin : g_bad_params
    $error("seg_scan_mux: REFRESH_DIV and BLANK_CYCLES must both be at least 1");
  end

  scan_state_t           state, state_nx;
  logic [IW-1:0]         idx, idx_nx;
  logic [CW-1:0]         cnt, cnt_nx;
  logic                  frame_end;

  logic [4*NUM_DIGITS-1:0] pend_digits, act_digits;
  logic [NUM_DIGITS-1:0]   pend_dp, act_dp;

  logic [3:0]            act_nibble;
  logic                  act_dp_bit;
  logic [7:0]            dec_seg;
  logic                  blank_digit;
  logic [NUM_DIGITS-1:0] onehot;
  logic [7:0]            seg_p0;
  logic [NUM_DIGITS-1:0] dig_p0;

  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      state <= BLANK;
      idx   <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      idx   <= idx_nx;
      cnt   <= cnt_nx;
    end
  end

  // Frame end is the last SHOW cycle of the highest digit.
  always_comb begin
    state_nx  = state;
    idx_nx    = idx;
    cnt_nx    = cnt + 1'b1;
    frame_end = 1'b0;
    case (state)
      BLANK: begin
        if (cnt == BLANK_LAST) begin
          state_nx = SHOW;
          cnt_nx   = '0;
        end
      end
      SHOW: begin
        if (cnt == SHOW_LAST) begin
          state_nx = BLANK;
          cnt_nx   = '0;
          if (idx == IDX_LAST) begin
            idx_nx    = '0;
            frame_end = 1'b1;
          end else begin
            idx_nx = idx + 1'b1;
          end
        end
      end
      default: begin
        state_nx = BLANK;
        cnt_nx   = '0;
      end
    endcase
  end

  // Pending is full exactly when load_ready is low, so transfer and accept
  // can never coincide; a load in the frame-end cycle stays in pending.
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      pend_digits <= '0;
      pend_dp     <= '0;
      act_digits  <= '0;
      act_dp      <= '0;
      load_ready  <= 1'b1;
    end else if (frame_end && !load_ready) begin
      act_digits <= pend_digits;
      act_dp     <= pend_dp;
      load_ready <= 1'b1;
    end else if (load_valid && load_ready) begin
      pend_digits <= load_digits;
      pend_dp     <= load_dp;
      load_ready  <= 1'b0;
    end
  end

  assign act_nibble = act_digits[{idx, 2'b00} +: 4];
  assign act_dp_bit = act_dp[idx];

  seg_decoder u_dec (
    .nibble (act_nibble),
    .dp     (act_dp_bit),
    .seg    (dec_seg)
  );

`ifdef LEADING_ZERO_BLANK_EN
  logic [IW-1:0] top_nz;

  // Digit 0 is the floor, so it is never blanked even for an all-zero word.
  always_comb begin
    top_nz = '0;
    for (int k = 1; k < NUM_DIGITS; k++) begin
      if (act_digits[4*k +: 4] != 4'h0) top_nz = IW'(k);
    end
  end

  assign blank_digit = (idx > top_nz);
`else
  assign blank_digit = 1'b0;
`endif

  always_comb begin
    onehot      = '0;
    onehot[idx] = 1'b1;
    seg_p0      = '0;
    dig_p0      = '0;
    if (state == SHOW) begin
      seg_p0 = {dec_seg[SEG_DP], blank_digit ? 7'h00 : dec_seg[6:0]};
      dig_p0 = onehot;
    end
  end

  // ---- output register stage ----
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      seg_out    <= '0;
      dig_sel    <= '0;
      frame_tick <= 1'b0;
    end else begin
      seg_out    <= seg_p0;
      dig_sel    <= dig_p0;
      frame_tick <= frame_end;
    end
  end

endmodule

// File: tb/tb_seg_scan_mux.sv
// Randomised bench for seg_scan_mux (4 digits, 4 show + 2 blank cycles) against
// a frame-position reference model.
module tb_seg_scan_mux;

  localparam int FRAME = 24;
  localparam int SLOT  = 6;
  localparam int BLNK  = 2;

  localparam logic [6:0] HEX7 [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  logic        CLOCK;
  logic        RESET_N;
  logic        load_valid;
  logic        load_ready;
  logic [15:0] load_digits;
  logic [3:0]  load_dp;
  logic [7:0]  seg_out;
  logic [3:0]  dig_sel;
  logic        frame_tick;

  int checks;
  int errors;

  int          m_t;
  logic        m_full;
  logic [15:0] m_pend, m_act;
  logic [3:0]  m_pend_dp, m_act_dp;
  logic [7:0]  e_seg;
  logic [3:0]  e_dig;
  logic        e_tick, e_ready;

  seg_scan_mux #(
    .NUM_DIGITS   (4),
    .REFRESH_DIV  (4),
    .BLANK_CYCLES (2)
  ) dut (
    .CLOCK       (CLOCK),
    .RESET_N     (RESET_N),
    .load_valid  (load_valid),
    .load_ready  (load_ready),
    .load_digits (load_digits),
    .load_dp     (load_dp),
    .seg_out     (seg_out),
    .dig_sel     (dig_sel),
    .frame_tick  (frame_tick)
  );

  initial CLOCK = 1'b0;
  always #5 CLOCK = ~CLOCK;

  function automatic logic [7:0] ref_digit(input logic [15:0] word, input logic [3:0] dp,
                                           input int d);
    logic [6:0] s;
    s = HEX7[word[4*d +: 4]];
`ifdef LEADING_ZERO_BLANK_EN
    begin
      int hi;
      hi = 0;
      for (int k = 0; k < 4; k++) if (word[4*k +: 4] != 4'h0) hi = k;
      if (d > hi) s = 7'h00;
    end
`endif
    return {dp[d], s};
  endfunction

  task automatic model_reset();
    m_t       = 0;
    m_full    = 1'b0;
    m_pend    = '0;
    m_pend_dp = '0;
    m_act     = '0;
    m_act_dp  = '0;
  endtask

  // Advance one clock; leaves the expected post-edge outputs in e_*.
  task automatic step();
    int p, d, w;
    logic xfer, acc;
    logic [15:0] in_d;
    logic [3:0]  in_dp;
    p     = m_t % FRAME;
    d     = p / SLOT;
    w     = p % SLOT;
    xfer  = (p == FRAME - 1) && m_full;
    acc   = load_valid && !m_full;
    in_d  = load_digits;
    in_dp = load_dp;
    if (w >= BLNK) begin
      e_seg = ref_digit(m_act, m_act_dp, d);
      e_dig = 4'(1 << d);
    end else begin
      e_seg = 8'h00;
      e_dig = 4'h0;
    end
    e_tick = (p == FRAME - 1);
    @(posedge CLOCK);
    if (xfer) begin
      m_act    = m_pend;
      m_act_dp = m_pend_dp;
      m_full   = 1'b0;
    end
    if (acc) begin
      m_pend    = in_d;
      m_pend_dp = in_dp;
      m_full    = 1'b1;
    end
    e_ready = !m_full;
    m_t++;
    #1;
  endtask

  task automatic do_reset();
    RESET_N    = 1'b0;
    load_valid = 1'b0;
    repeat (2) @(negedge CLOCK);
    RESET_N = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    #2 RESET_N = 1'b0;
    #1;
    checks++;
    if ({seg_out, dig_sel, frame_tick, load_ready} !== {8'h00, 4'h0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL reset_state got seg=%h dig=%b tick=%b rdy=%b exp seg=00 dig=0000 tick=0 rdy=1",
               seg_out, dig_sel, frame_tick, load_ready);
    end
    repeat (2) @(negedge CLOCK);
    RESET_N = 1'b1;
    model_reset();
    for (int i = 0; i < FRAME; i++) begin
      step();
      checks++;
      if ({seg_out, dig_sel, frame_tick, load_ready} !== {e_seg, e_dig, e_tick, e_ready}) begin
        errors++;
        $display("FAIL reset_frame t=%0d got %h/%b/%b/%b exp %h/%b/%b/%b", m_t, seg_out, dig_sel,
                 frame_tick, load_ready, e_seg, e_dig, e_tick, e_ready);
      end
      if (i == BLNK) begin
        checks++;
        if (dig_sel !== 4'b0001) begin
          errors++;
          $display("FAIL reset_first_digit got dig=%b exp dig=0001", dig_sel);
        end
      end
    end
  endtask

  task automatic test_load_1234();
    int hits;
    hits = 0;
    do_reset();
    load_valid  = 1'b1;
    load_digits = 16'h1234;
    load_dp     = 4'b0000;
    step();
    load_valid = 1'b0;
    for (int i = 1; i < 2 * FRAME; i++) begin
      step();
      checks++;
      if ({seg_out, dig_sel, frame_tick, load_ready} !== {e_seg, e_dig, e_tick, e_ready}) begin
        errors++;
        $display("FAIL load1234 t=%0d got %h/%b/%b/%b exp %h/%b/%b/%b", m_t, seg_out, dig_sel,
                 frame_tick, load_ready, e_seg, e_dig, e_tick, e_ready);
      end
      if (m_t > FRAME + 1) begin
        if (dig_sel == 4'b0001) begin
          hits++;
          checks++;
          if (seg_out !== 8'h66) begin
            errors++;
            $display("FAIL load1234_digit0 got seg=%h exp seg=66", seg_out);
          end
        end
        if (dig_sel == 4'b1000 && !frame_tick) begin
          hits++;
          checks++;
          if (seg_out !== 8'h06) begin
            errors++;
            $display("FAIL load1234_digit3 got seg=%h exp seg=06", seg_out);
          end
        end
      end
    end
    checks++;
    if (hits != 7) begin
      errors++;
      $display("FAIL load1234_coverage got %0d digit cycles exp 7", hits);
    end
  endtask

  task automatic test_back_to_back();
    int n_acc, acc_phase;
    logic pre_ready;
    n_acc       = 0;
    acc_phase   = -1;
    load_valid  = 1'b1;
    load_digits = 16'h1111;
    load_dp     = 4'b0000;
    for (int i = 0; i < 4 * FRAME && n_acc < 2; i++) begin
      pre_ready = load_ready;
      step();
      checks++;
      if ({seg_out, dig_sel, frame_tick, load_ready} !== {e_seg, e_dig, e_tick, e_ready}) begin
        errors++;
        $display("FAIL b2b t=%0d got %h/%b/%b/%b exp %h/%b/%b/%b", m_t, seg_out, dig_sel,
                 frame_tick, load_ready, e_seg, e_dig, e_tick, e_ready);
      end
      if (pre_ready) begin
        n_acc++;
        if (n_acc == 1) load_digits = 16'h2222;
        else acc_phase = (m_t - 1) % FRAME;
      end
    end
    load_valid = 1'b0;
    checks++;
    if (acc_phase !== 0) begin
      errors++;
      $display("FAIL b2b_accept_phase got %0d exp 0", acc_phase);
    end
    for (int i = 0; i < 2 * FRAME; i++) begin
      step();
      checks++;
      if ({seg_out, dig_sel, frame_tick, load_ready} !== {e_seg, e_dig, e_tick, e_ready}) begin
        errors++;
        $display("FAIL b2b_drain t=%0d got %h/%b/%b/%b exp %h/%b/%b/%b", m_t, seg_out, dig_sel,
                 frame_tick, load_ready, e_seg, e_dig, e_tick, e_ready);
      end
    end
  endtask

  task automatic test_frame_end_load();
    for (int i = 0; i < FRAME && (m_t % FRAME) != FRAME - 1; i++) step();
    checks++;
    if (load_ready !== 1'b1) begin
      errors++;
      $display("FAIL fe_load_ready_before got %b exp 1", load_ready);
    end
    load_valid  = 1'b1;
    load_digits = 16'($urandom);
    load_dp     = 4'($urandom);
    step();
    load_valid = 1'b0;
    checks++;
    if ({frame_tick, load_ready} !== 2'b10) begin
      errors++;
      $display("FAIL fe_load_pending got tick=%b rdy=%b exp tick=1 rdy=0", frame_tick, load_ready);
    end
    for (int i = 0; i < 2 * FRAME; i++) begin
      step();
      checks++;
      if ({seg_out, dig_sel, frame_tick, load_ready} !== {e_seg, e_dig, e_tick, e_ready}) begin
        errors++;
        $display("FAIL fe_load t=%0d got %h/%b/%b/%b exp %h/%b/%b/%b", m_t, seg_out, dig_sel,
                 frame_tick, load_ready, e_seg, e_dig, e_tick, e_ready);
      end
    end
  endtask

  task automatic test_dp();
    logic [15:0] word;
    int hits;
    hits        = 0;
    word        = 16'($urandom);
    load_valid  = 1'b1;
    load_digits = word;
    load_dp     = 4'b0100;
    step();
    load_valid = 1'b0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      step();
      checks++;
      if ({seg_out, dig_sel, frame_tick, load_ready} !== {e_seg, e_dig, e_tick, e_ready}) begin
        errors++;
        $display("FAIL dp t=%0d got %h/%b/%b/%b exp %h/%b/%b/%b", m_t, seg_out, dig_sel,
                 frame_tick, load_ready, e_seg, e_dig, e_tick, e_ready);
      end
      if (m_act == word && m_act_dp == 4'b0100 && !frame_tick && dig_sel != 4'h0) begin
        hits++;
        checks++;
        if (seg_out[7] !== (dig_sel == 4'b0100)) begin
          errors++;
          $display("FAIL dp_bit dig=%b got dp=%b exp dp=%b", dig_sel, seg_out[7],
                   dig_sel == 4'b0100);
        end
      end
    end
    checks++;
    if (hits == 0) begin
      errors++;
      $display("FAIL dp_coverage got 0 digit cycles exp >0");
    end
  endtask

  task automatic test_leading_zero();
    logic [7:0] exp_hi;
    int hits;
`ifdef LEADING_ZERO_BLANK_EN
    exp_hi = 8'h00;
`else
    exp_hi = 8'h3F;
`endif
    hits        = 0;
    load_valid  = 1'b1;
    load_digits = 16'h0050;
    load_dp     = 4'b0000;
    step();
    load_valid = 1'b0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      step();
      if (m_act == 16'h0050 && m_act_dp == 4'b0000 && !frame_tick && dig_sel != 4'h0) begin
        logic [7:0] want;
        case (dig_sel)
          4'b0001: want = 8'h3F;
          4'b0010: want = 8'h6D;
          default: want = exp_hi;
        endcase
        hits++;
        checks++;
        if (seg_out !== want) begin
          errors++;
          $display("FAIL lzb dig=%b got seg=%h exp seg=%h", dig_sel, seg_out, want);
        end
      end
    end
    checks++;
    if (hits == 0) begin
      errors++;
      $display("FAIL lzb_coverage got 0 digit cycles exp >0");
    end
  endtask

  task automatic test_random_run();
    int ticks, zero_run;
    ticks = 0;
    for (int i = 0; i < 6 * FRAME; i++) begin
      load_valid  = ($urandom_range(0, 3) == 0);
      load_digits = 16'($urandom);
      load_dp     = 4'($urandom);
      step();
      checks++;
      if ({seg_out, dig_sel, frame_tick, load_ready} !== {e_seg, e_dig, e_tick, e_ready}) begin
        errors++;
        $display("FAIL random t=%0d got %h/%b/%b/%b exp %h/%b/%b/%b", m_t, seg_out, dig_sel,
                 frame_tick, load_ready, e_seg, e_dig, e_tick, e_ready);
      end
      checks++;
      if (!$onehot0(dig_sel)) begin
        errors++;
        $display("FAIL random_onehot got dig=%b exp at most one bit", dig_sel);
      end
      if (frame_tick) ticks++;
    end
    load_valid = 1'b0;
    checks++;
    if (ticks != 6) begin
      errors++;
      $display("FAIL random_tick_count got %0d exp 6", ticks);
    end
    zero_run = 0;
    for (int i = 0; i < FRAME; i++) begin
      step();
      if (dig_sel == 4'h0) zero_run++;
    end
    checks++;
    if (zero_run != 4 * BLNK) begin
      errors++;
      $display("FAIL random_blank_cycles got %0d exp %0d", zero_run, 4 * BLNK);
    end
  endtask

  task automatic test_reset_mid();
    int found;
    found       = 0;
    load_valid  = 1'b1;
    load_digits = 16'h9876;
    load_dp     = 4'b1111;
    for (int i = 0; i < 3 * FRAME && found == 0; i++) begin
      step();
      if (dig_sel == 4'b0100) found = 1;
    end
    checks++;
    if (found == 0) begin
      errors++;
      $display("FAIL rst_mid_reach got no digit 2 exp digit 2 within budget");
    end
    #2 RESET_N = 1'b0;
    #1;
    checks++;
    if ({seg_out, dig_sel, frame_tick, load_ready} !== {8'h00, 4'h0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL rst_mid_state got seg=%h dig=%b tick=%b rdy=%b exp seg=00 dig=0000 tick=0 rdy=1",
               seg_out, dig_sel, frame_tick, load_ready);
    end
    load_valid = 1'b0;
    repeat (2) @(negedge CLOCK);
    RESET_N = 1'b1;
    model_reset();
    for (int i = 0; i < 2 * FRAME; i++) begin
      step();
      checks++;
      if ({seg_out, dig_sel, frame_tick, load_ready} !== {e_seg, e_dig, e_tick, e_ready}) begin
        errors++;
        $display("FAIL rst_mid_after t=%0d got %h/%b/%b/%b exp %h/%b/%b/%b", m_t, seg_out,
                 dig_sel, frame_tick, load_ready, e_seg, e_dig, e_tick, e_ready);
      end
      if (i == BLNK) begin
        checks++;
        if ({seg_out, dig_sel} !== {8'h3F, 4'b0001}) begin
          errors++;
          $display("FAIL rst_mid_restart got seg=%h dig=%b exp seg=3F dig=0001", seg_out, dig_sel);
        end
      end
    end
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    RESET_N     = 1'b1;
    load_valid  = 1'b0;
    load_digits = '0;
    load_dp     = '0;
    model_reset();
    test_reset();
    test_load_1234();
    test_back_to_back();
    test_frame_end_load();
    test_dp();
    test_leading_zero();
    test_random_run();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seg_scan_mux.md
SEG_SCAN_MUX -- requirements
Module: seg_scan_mux

Interface
REQ-001 Parameters SHALL be:
- NUM_DIGITS, default 4, number of multiplexed digits.
- REFRESH_DIV, default 5000, SHOW cycles per digit (1 kHz digit rate at 5 MHz).
- BLANK_CYCLES, default 50, anti-ghosting blank cycles before each digit.

REQ-002 Ports SHALL be:
- CLOCK  in  1  single clock.
- RESET_N  in  1  reset, asynchronous, active-low.
- load_valid  in  1  new display word offered.
- load_ready  out  1  pending buffer empty.
- load_digits  in  4*NUM_DIGITS  hex nibbles; nibble k drives digit k, digit 0 rightmost.
- load_dp  in  NUM_DIGITS  decimal point per digit.
- seg_out  out  8  active-high segments; bit0=a … bit6=g, bit7=dp.
- dig_sel  out  NUM_DIGITS  active-high one-hot digit enable.
- frame_tick  out  1  one-cycle pulse at the end of each frame.

Function
REQ-003 A load SHALL be accepted on a rising CLOCK edge where load_valid && load_ready; the word is captured into the pending buffer and load_ready drops the next cycle.
REQ-004 FSM states SHALL be BLANK and SHOW.
- BLANK: dig_sel=0, seg_out=0, held for BLANK_CYCLES cycles, then go to SHOW.
- SHOW: dig_sel=one-hot(idx), seg_out=decode(active nibble idx, active dp idx), held for REFRESH_DIV cycles, then go to BLANK.
REQ-005 On leaving SHOW, idx SHALL increment; from NUM_DIGITS-1 it wraps to 0, and that wrap is the frame end.
REQ-006 At frame end, frame_tick SHALL pulse for 1 cycle. If pending was full at the start of that cycle:
- pending is copied to the active buffer;
- pending is marked empty;
- load_ready rises the next cycle.
REQ-007 A load accepted in the same cycle as frame end SHALL land in pending and not be transferred in that cycle. Active contents SHALL change only at frame end, so no tearing occurs.
REQ-008 Frame length SHALL be NUM_DIGITS*(BLANK_CYCLES+REFRESH_DIV) cycles exactly.
REQ-009 Decode SHALL be full hex: 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71 (bits 6:0). bit7 SHALL equal dp.
REQ-010 The cycle counter SHALL be $clog2(max(REFRESH_DIV,BLANK_CYCLES)+1) bits wide. REFRESH_DIV≥1 and BLANK_CYCLES≥1 SHALL be enforced by elaboration assertion.
REQ-011 All outputs SHALL be registered (1-cycle latency from state/idx to pins).

Reset
REQ-012 RESET_N low SHALL immediately force:
- seg_out=0, dig_sel=0, frame_tick=0, load_ready=1;
- state=BLANK, idx=0, counter=0;
- active buffer=0, pending empty.
REQ-013 Reset asserted mid-SHOW or mid-load SHALL discard pending and active contents; no partial transfer.

Configuration
REQ-014 With LEADING_ZERO_BLANK_EN defined, digits at indices above the highest non-zero active nibble SHALL show seg bits 6:0 = 0 (dp still honoured). Digit 0 SHALL never be blanked.
REQ-015 Without LEADING_ZERO_BLANK_EN, every digit SHALL be decoded as in REQ-009.

Structure
REQ-016 Package seg_pkg SHALL hold the 16-entry segment constant table, segment bit-index constants and the state enum typedef.
REQ-017 The combinational sub-module seg_decoder (nibble+dp -> 8-bit segments) SHALL be instantiated once.

Verification
All scenarios use NUM_DIGITS=4, REFRESH_DIV=4, BLANK_CYCLES=2 (frame = 24 cycles).
REQ-018 Reset release, load 0x1234, dp=0 -> after first frame end:
- digit 0: seg_out=0x66, dig_sel=0001;
- digit 3: seg_out=0x06, dig_sel=1000.
REQ-019 load_valid held with 0x1111 then 0x2222 -> second word waits with load_ready=0 until the cycle after frame end, then is accepted.
REQ-020 Load 0x0050 with the macro defined -> digits 3 and 2 show 0x00, digit 1 shows 0x6D, digit 0 shows 0x3F. Without the macro, digits 3 and 2 show 0x3F.
REQ-021 load_dp=4'b0100 -> only digit 2 has seg_out[7]=1.
REQ-022 Free run -> frame_tick high exactly 1 cycle in every 24; dig_sel never has more than one bit set; dig_sel=0 for 2 cycles between digits.
REQ-023 RESET_N low during SHOW of digit 2 -> seg_out and dig_sel read 0 in the same cycle, load_ready=1; after release, a scan restarts at digit 0 with blank contents.
